counter_core: RTL and testbench

COUNTER_CORE -- requirements
Module: counter_core

---
 rtl/counter_pkg.sv | 29 ++
 rtl/counter_prescaler.sv | 41 ++++
 rtl/counter_core.sv | 148 ++++++++++++++
 tb/tb_counter_core.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the counter_core slice:
//   - FSM state encoding (IDLE=0, RUN=1, HALT=2)
//   - bit positions of the fields in the control word
//   - register-map addresses and reset values of the control/limit registers
// -----------------------------------------------------------------------------
package counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_e;

   // Control word field positions
   localparam int CTRL_EN_BIT      = 0;
   localparam int CTRL_DOWN_BIT    = 1;
   localparam int CTRL_ONESHOT_BIT = 2;
   localparam int CTRL_CLR_BIT     = 3;
   localparam int CTRL_PSC_LSB     = 8;

   // Register map
   localparam logic [7:0]  ADDR_CTRL   = 8'h00;
   localparam logic [7:0]  ADDR_LIMIT  = 8'h08;
   localparam logic [31:0] CTRL_RESET  = 32'h0000_0000;
   localparam logic [31:0] LIMIT_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/counter_prescaler.sv
// -----------------------------------------------------------------------------
// counter_prescaler
// Divides the clock into a tick every psc+1 cycles.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   restart  - holds the divider at 0 (count restarts on the following cycle)
//   psc      - division value; tick period is psc+1 cycles
//   tick     - high in the last cycle of each period
// -----------------------------------------------------------------------------
module counter_prescaler #(
   parameter int PSC_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             restart,
   input  logic [PSC_W-1:0] psc,
   output logic             tick
);

   localparam logic [PSC_W-1:0] PSC_ONE = PSC_W'(1);

   logic [PSC_W-1:0] psc_cnt;

   // '>=' rather than '==' so a psc lowered below the running count
   // terminates the period instead of running round the full range.
   assign tick = (psc_cnt >= psc);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         psc_cnt <= '0;
      end else if (restart || tick) begin
         psc_cnt <= '0;
      end else begin
         psc_cnt <= psc_cnt + PSC_ONE;
      end
   end

endmodule

// File: rtl/counter_core.sv
// -----------------------------------------------------------------------------
// counter_core
// Up/down counter with programmable terminal value, optional prescaler,
// one-shot mode and sticky overflow flag.
// Build option: define COUNTER_PRESCALER_EN to compile in the prescaler
// (tick every PSC+1 cycles); otherwise the counter ticks every RUN cycle
// and the PSC field is ignored.
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   ctrl_i     - control word: [0] EN, [1] DOWN, [2] ONESHOT, [3] CLR,
//                [8+PSC_W-1:8] PSC
//   limit_i    - terminal count value
//   ovf_clr_i  - clears the sticky overflow flag
//   cnt_o      - current count
//   ovf_o      - sticky overflow flag
//   ovf_pls_o  - one-cycle pulse following each wrap
//   state_o    - FSM state (IDLE=0, RUN=1, HALT=2)
// -----------------------------------------------------------------------------
module counter_core
   import counter_pkg::*;
#(
   parameter int CNT_W = 32,
   parameter int PSC_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      ctrl_i,
   input  logic [CNT_W-1:0] limit_i,
   input  logic             ovf_clr_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             ovf_o,
   output logic             ovf_pls_o,
   output logic [1:0]       state_o
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic en, down, oneshot, clr;
   assign en      = ctrl_i[CTRL_EN_BIT];
   assign down    = ctrl_i[CTRL_DOWN_BIT];
   assign oneshot = ctrl_i[CTRL_ONESHOT_BIT];
   assign clr     = ctrl_i[CTRL_CLR_BIT];

   // Bits outside the decoded fields are deliberately ignored.
   logic unused_ctrl;
   assign unused_ctrl = ^ctrl_i;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_nxt;
   logic             ovf_q;
   logic             pls_q;

   // Counting is enabled only in RUN with EN still set; the cycle that
   // drops EN leaves the count untouched.
   logic count_en;
   assign count_en = (state_q == ST_RUN) && en;

   logic tick;

`ifdef COUNTER_PRESCALER_EN
   logic psc_tick;

   // Held in restart outside counting and on CLR, so every RUN entry
   // and every clear starts a fresh period.
   counter_prescaler #(
      .PSC_W (PSC_W)
   ) u_prescaler (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (clr || !count_en),
      .psc     (ctrl_i[CTRL_PSC_LSB +: PSC_W]),
      .tick    (psc_tick)
   );

   assign tick = count_en && psc_tick;
`else
   logic unused_psc;
   assign unused_psc = ^ctrl_i[CTRL_PSC_LSB +: PSC_W];
   assign tick       = count_en;
`endif

   // CLR takes priority over a tick in the same cycle.
   logic step;
   logic wrap_up, wrap_dn, wrap;
   assign step    = tick && !clr;
   assign wrap_up = (cnt_q >= limit_i);
   assign wrap_dn = (cnt_q == '0) || (cnt_q > limit_i);
   assign wrap    = step && (down ? wrap_dn : wrap_up);

   // NOTE: the default assignment first guarantees cnt_nxt is driven on
   // every path, so no latch is inferred.
   always_comb begin
      cnt_nxt = cnt_q;
      if (clr) begin
         cnt_nxt = down ? limit_i : '0;
      end else if (step) begin
         if (down) begin
            cnt_nxt = wrap_dn ? limit_i : (cnt_q - CNT_ONE);
         end else begin
            cnt_nxt = wrap_up ? '0 : (cnt_q + CNT_ONE);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         pls_q   <= 1'b0;
      end else begin
         cnt_q <= cnt_nxt;
         pls_q <= wrap;

         // A wrap wins over a clear request in the same cycle.
         if (wrap) begin
            ovf_q <= 1'b1;
         end else if (ovf_clr_i) begin
            ovf_q <= 1'b0;
         end

         unique case (state_q)
            ST_IDLE: begin
               if (en) state_q <= ST_RUN;
            end
            ST_RUN: begin
               if (!en) begin
                  state_q <= ST_IDLE;
               end else if (wrap && oneshot) begin
                  state_q <= ST_HALT;
               end
            end
            ST_HALT: begin
               if (!en) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cnt_o     = cnt_q;
   assign ovf_o     = ovf_q;
   assign ovf_pls_o = pls_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_counter_core.sv
// -----------------------------------------------------------------------------
// tb_counter_core
// Self-checking bench for counter_core. Each applied vector pushes its
// expected post-edge outputs into a scoreboard queue; the entry is popped
// and compared one time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_counter_core;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HALT = 2'd2;

`ifdef COUNTER_PRESCALER_EN
   localparam int PSC_PERIOD = 3;
`else
   localparam int PSC_PERIOD = 1;
`endif

   typedef struct {
      logic [31:0] ctrl;
      logic [31:0] limit;
      logic        ovf_clr;
      logic [31:0] cnt;
      logic        ovf;
      logic        pls;
      logic [1:0]  st;
   } vec_t;

   typedef struct {
      logic [31:0] cnt;
      logic        ovf;
      logic        pls;
      logic [1:0]  st;
   } exp_t;

   logic        clk;
   logic        clk_en;
   logic        rst_n;
   logic [31:0] ctrl_i;
   logic [31:0] limit_i;
   logic        ovf_clr_i;
   logic [31:0] cnt_o;
   logic        ovf_o;
   logic        ovf_pls_o;
   logic [1:0]  state_o;

   int   checks;
   int   failures;
   exp_t exp_q[$];
   vec_t tbl[$];

   counter_core dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ctrl_i    (ctrl_i),
      .limit_i   (limit_i),
      .ovf_clr_i (ovf_clr_i),
      .cnt_o     (cnt_o),
      .ovf_o     (ovf_o),
      .ovf_pls_o (ovf_pls_o),
      .state_o   (state_o)
   );

   // Gateable clock so reset can be exercised with the clock stopped.
   initial clk = 1'b0;
   always #5 if (clk_en) clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, ".cnt"},   cnt_o,           32'h0);
      check({tag, ".ovf"},   {31'h0, ovf_o},     32'h0);
      check({tag, ".pls"},   {31'h0, ovf_pls_o}, 32'h0);
      check({tag, ".state"}, {30'h0, state_o},   {30'h0, S_IDLE});
   endtask

   function automatic vec_t mk(input logic [31:0] ctrl, input logic [31:0] limit,
                               input logic ovf_clr, input logic [31:0] cnt,
                               input logic ovf, input logic pls, input logic [1:0] st);
      vec_t v;
      v.ctrl = ctrl; v.limit = limit; v.ovf_clr = ovf_clr;
      v.cnt  = cnt;  v.ovf   = ovf;   v.pls     = pls; v.st = st;
      return v;
   endfunction

   // Drive one vector, queue its expectation, compare after the edge.
   task automatic step(input vec_t v, input string tag);
      exp_t e;
      ctrl_i    = v.ctrl;
      limit_i   = v.limit;
      ovf_clr_i = v.ovf_clr;
      e.cnt = v.cnt; e.ovf = v.ovf; e.pls = v.pls; e.st = v.st;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check({tag, ".scoreboard_empty"}, 32'h1, 32'h0);
      end else begin
         e = exp_q.pop_front();
         check({tag, ".cnt"},   cnt_o,               e.cnt);
         check({tag, ".ovf"},   {31'h0, ovf_o},      {31'h0, e.ovf});
         check({tag, ".pls"},   {31'h0, ovf_pls_o},  {31'h0, e.pls});
         check({tag, ".state"}, {30'h0, state_o},    {30'h0, e.st});
      end
   endtask

   task automatic run_tbl(input string tag);
      foreach (tbl[i]) step(tbl[i], $sformatf("%s[%0d]", tag, i));
      tbl.delete();
   endtask

   // Assert reset between edges, check outputs, release before next edge.
   task automatic do_reset(input string tag);
      @(negedge clk);
      rst_n     = 1'b0;
      ctrl_i    = 32'h0;
      ovf_clr_i = 1'b0;
      #1;
      check_reset_vals(tag);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int seq_dn[7];
      logic [31:0] prev;
      logic        ovf_e;

      checks    = 0;
      failures  = 0;
      clk_en    = 1'b1;
      rst_n     = 1'b0;
      ctrl_i    = 32'h0;
      limit_i   = 32'hFFFF_FFFF;
      ovf_clr_i = 1'b0;

      do_reset("reset0");

      // Count up to 3, wrap, then stop, clear and mid-run limit/direction changes.
      tbl.push_back(mk(32'h1, 32'd3, 1'b0, 32'd0, 1'b0, 1'b0, S_RUN));
      tbl.push_back(mk(32'h1, 32'd3, 1'b0, 32'd1, 1'b0, 1'b0, S_RUN));
      tbl.push_back(mk(32'h1, 32'd3, 1'b0, 32'd2, 1'b0, 1'b0, S_RUN));
      tbl.push_back(mk(32'h1, 32'd3, 1'b0, 32'd3, 1'b0, 1'b0, S_RUN));
      tbl.push_back(mk(32'h1, 32'd3, 1'b0, 32'd0, 1'b1, 1'b1, S_RUN));
      tbl.push_back(mk(32'h1, 32'd3, 1'b0, 32'd1, 1'b1, 1'b0, S_RUN));
      tbl.push_back(mk(32'h0, 32'd3, 1'b0, 32'd1, 1'b1, 1'b0, S_IDLE));
      tbl.push_back(mk(32'h8, 32'd3, 1'b0, 32'd0, 1'b1, 1'b0, S_IDLE));
      tbl.push_back(mk(32'h0, 32'd3, 1'b1, 32'd0, 1'b0, 1'b0, S_IDLE));
      // limit 0: every tick wraps, count stays 0
      tbl.push_back(mk(32'h1, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, S_RUN));
      tbl.push_back(mk(32'h1, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, S_RUN));
      tbl.push_back(mk(32'h1, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, S_RUN));
      // limit lowered below the count mid-run
      tbl.push_back(mk(32'h1, 32'd100, 1'b0, 32'd1, 1'b1, 1'b0, S_RUN));
      tbl.push_back(mk(32'h1, 32'd100, 1'b0, 32'd2, 1'b1, 1'b0, S_RUN));
      tbl.push_back(mk(32'h1, 32'd100, 1'b0, 32'd3, 1'b1, 1'b0, S_RUN));
      tbl.push_back(mk(32'h1, 32'd100, 1'b0, 32'd4, 1'b1, 1'b0, S_RUN));
      tbl.push_back(mk(32'h1, 32'd2,   1'b0, 32'd0, 1'b1, 1'b1, S_RUN));
      // direction switched mid-run, then down-wrap from 0 and from above limit
      tbl.push_back(mk(32'h1, 32'd100, 1'b0, 32'd1,   1'b1, 1'b0, S_RUN));
      tbl.push_back(mk(32'h1, 32'd100, 1'b0, 32'd2,   1'b1, 1'b0, S_RUN));
      tbl.push_back(mk(32'h3, 32'd100, 1'b0, 32'd1,   1'b1, 1'b0, S_RUN));
      tbl.push_back(mk(32'h3, 32'd100, 1'b0, 32'd0,   1'b1, 1'b0, S_RUN));
      tbl.push_back(mk(32'h3, 32'd100, 1'b0, 32'd100, 1'b1, 1'b1, S_RUN));
      tbl.push_back(mk(32'h3, 32'd50,  1'b0, 32'd50,  1'b1, 1'b1, S_RUN));
      // CLR beats a tick: loads limit when counting down, 0 when counting up
      tbl.push_back(mk(32'hB, 32'd50,  1'b0, 32'd50,  1'b1, 1'b0, S_RUN));
      tbl.push_back(mk(32'h9, 32'd50,  1'b0, 32'd0,   1'b1, 1'b0, S_RUN));
      tbl.push_back(mk(32'h9, 32'd50,  1'b0, 32'd0,   1'b1, 1'b0, S_RUN));
      tbl.push_back(mk(32'h1, 32'd50,  1'b0, 32'd1,   1'b1, 1'b0, S_RUN));
      run_tbl("up3");

      // One-shot: 1,2,0 then HALT holding 0; EN low returns to IDLE.
      do_reset("reset_os");
      tbl.push_back(mk(32'h5, 32'd2, 1'b0, 32'd0, 1'b0, 1'b0, S_RUN));
      tbl.push_back(mk(32'h5, 32'd2, 1'b0, 32'd1, 1'b0, 1'b0, S_RUN));
      tbl.push_back(mk(32'h5, 32'd2, 1'b0, 32'd2, 1'b0, 1'b0, S_RUN));
      tbl.push_back(mk(32'h5, 32'd2, 1'b0, 32'd0, 1'b1, 1'b1, S_HALT));
      tbl.push_back(mk(32'h5, 32'd2, 1'b0, 32'd0, 1'b1, 1'b0, S_HALT));
      tbl.push_back(mk(32'h5, 32'd2, 1'b0, 32'd0, 1'b1, 1'b0, S_HALT));
      tbl.push_back(mk(32'h0, 32'd2, 1'b0, 32'd0, 1'b1, 1'b0, S_IDLE));
      run_tbl("oneshot");

      // Clear coinciding with a wrap keeps the flag; a lone clear drops it.
      do_reset("reset_clr");
      tbl.push_back(mk(32'h1, 32'd1, 1'b0, 32'd0, 1'b0, 1'b0, S_RUN));
      tbl.push_back(mk(32'h1, 32'd1, 1'b0, 32'd1, 1'b0, 1'b0, S_RUN));
      tbl.push_back(mk(32'h1, 32'd1, 1'b1, 32'd0, 1'b1, 1'b1, S_RUN));
      tbl.push_back(mk(32'h1, 32'd1, 1'b1, 32'd1, 1'b0, 1'b0, S_RUN));
      tbl.push_back(mk(32'h1, 32'd1, 1'b0, 32'd0, 1'b1, 1'b1, S_RUN));
      run_tbl("ovf_clr");

      // Down count with PSC=2 from reset: first tick wraps 0 -> 5.
      do_reset("reset_dn");
      seq_dn = '{5, 4, 3, 2, 1, 0, 5};
      tbl.push_back(mk(32'h203, 32'd5, 1'b0, 32'd0, 1'b0, 1'b0, S_RUN));
      prev  = 32'd0;
      ovf_e = 1'b0;
      for (int k = 0; k < 7; k++) begin
         for (int j = 1; j <= PSC_PERIOD; j++) begin
            if (j < PSC_PERIOD) begin
               tbl.push_back(mk(32'h203, 32'd5, 1'b0, prev, ovf_e, 1'b0, S_RUN));
            end else begin
               ovf_e = 1'b1;
               prev  = 32'(seq_dn[k]);
               tbl.push_back(mk(32'h203, 32'd5, 1'b0, prev, 1'b1,
                                (k == 0) || (k == 6), S_RUN));
            end
         end
      end
      run_tbl("down_psc");

      // Run to 0x10, then reset with the clock stopped.
      do_reset("reset_mid");
      for (int i = 0; i <= 16; i++) begin
         tbl.push_back(mk(32'h1, 32'hFF, 1'b0, 32'(i), 1'b0, 1'b0, S_RUN));
      end
      run_tbl("run16");
      @(negedge clk);
      clk_en = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals("async_rst");
      #2;
      ctrl_i = 32'h0;
      rst_n  = 1'b1;
      #1;
      clk_en = 1'b1;
      @(posedge clk);
      #1;
      tbl.push_back(mk(32'h1, 32'hFF, 1'b0, 32'd0, 1'b0, 1'b0, S_RUN));
      tbl.push_back(mk(32'h1, 32'hFF, 1'b0, 32'd1, 1'b0, 1'b0, S_RUN));
      run_tbl("after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
